// File: rtl/char_font_pkg.sv
// char_font_pkg
//   Shared constants and helpers for the character glyph engine slice.
//   - CHAR_W_DEFAULT / CHAR_H_DEFAULT / NUM_CHARS_DEFAULT : default glyph geometry
//   - INVALID_MODE_BLANK / INVALID_MODE_SUB               : unmapped-code policies
//   - clog2()                                             : address width helper
package char_font_pkg;

    localparam int unsigned CHAR_W_DEFAULT    = 8;
    localparam int unsigned CHAR_H_DEFAULT    = 16;
    localparam int unsigned NUM_CHARS_DEFAULT = 64;

    // Policy for codes whose remap entry is not valid
    localparam int unsigned INVALID_MODE_BLANK = 0;  // blank row, slot 0
    localparam int unsigned INVALID_MODE_SUB   = 1;  // render the substitute slot

    // Ceiling log2, floored at 1 so a degenerate parameter never yields a zero-width bus
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/char_font_ram.sv
// char_font_ram
//   Simple dual-port synchronous RAM holding the glyph rows, one write port and
//   one registered read port. Contents are not reset. A read and a write to the
//   same address in one cycle return the old contents.
//   Ports:
//     clk      : clock
//     wr_en    : write strobe
//     wr_addr  : write address {index, row}
//     wr_data  : row pattern to store
//     rd_en    : read enable; rd_data holds its value while low
//     rd_addr  : read address {index, row}
//     rd_data  : registered read data
module char_font_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Sized to the full {index, row} address space so the packed address needs no
    // multiply; equals NUM_CHARS*CHAR_H for power-of-two geometry.
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/char_glyph_engine.sv
// char_glyph_engine
//   Two-stage pipeline turning (ASCII code, glyph row) requests into CHAR_W-bit
//   pixel rows. Stage 1 remaps the code through a runtime-loadable table, stage 2
//   reads the glyph row from the font RAM. Unmapped codes are counted.
//   Ports:
//     clk, rst_n                  : clock, asynchronous active-low reset
//     req_valid/req_ready         : request handshake
//     req_ascii, req_row          : character code and glyph row
//     out_valid/out_ready         : result handshake
//     out_bits                    : pixel row, MSB = leftmost pixel
//     out_index                   : resolved glyph slot
//     out_invalid                 : code unmapped or row out of range
//     map_we/map_ascii/map_index/map_en : remap table write port
//     font_we/font_addr/font_data : font RAM write port, address {index, row}
//     invalid_cnt, cnt_clr        : saturating invalid-result counter and its clear
module char_glyph_engine
    import char_font_pkg::*;
#(
    parameter  int unsigned CHAR_W       = CHAR_W_DEFAULT,
    parameter  int unsigned CHAR_H       = CHAR_H_DEFAULT,
    parameter  int unsigned NUM_CHARS    = NUM_CHARS_DEFAULT,
    parameter  int unsigned INVALID_MODE = INVALID_MODE_BLANK,
    parameter  int unsigned SUB_INDEX    = 0,
    localparam int unsigned IDX_W        = clog2(NUM_CHARS),
    localparam int unsigned ROW_W        = clog2(CHAR_H)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0]             req_ascii,
    input  logic [ROW_W-1:0]       req_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHAR_W-1:0]      out_bits,
    output logic [IDX_W-1:0]       out_index,
    output logic                   out_invalid,
    input  logic                   map_we,
    input  logic [7:0]             map_ascii,
    input  logic [IDX_W-1:0]       map_index,
    input  logic                   map_en,
    input  logic                   font_we,
    input  logic [IDX_W+ROW_W-1:0] font_addr,
    input  logic [CHAR_W-1:0]      font_data,
    output logic [15:0]            invalid_cnt,
    input  logic                   cnt_clr
);

    // ------------------------------------------------------------------
    // Remap table: unreset slot storage plus a reset-cleared valid vector
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] map_table [256];
    logic [255:0]     map_vld;

    always_ff @(posedge clk) begin
        if (map_we) begin
            map_table[map_ascii] <= map_index;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_vld <= '0;
        end else if (map_we) begin
            map_vld[map_ascii] <= map_en;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 lookup (combinational read; the table write lands at the same
    // edge, so a same-cycle lookup sees the old entry)
    // ------------------------------------------------------------------
    logic             lk_mapped;
    logic             lk_row_bad;
    logic [IDX_W-1:0] lk_index;
    logic             lk_zero;
    logic             lk_invalid;

    assign lk_mapped = map_vld[req_ascii];

    if (CHAR_H == (1 << ROW_W)) begin : g_row_pow2
        assign lk_row_bad = 1'b0;
    end else begin : g_row_chk
        assign lk_row_bad = (req_row >= ROW_W'(CHAR_H));
    end

    always_comb begin
        lk_index = '0;
        if (lk_mapped) begin
            lk_index = map_table[req_ascii];
        end else if (INVALID_MODE == INVALID_MODE_SUB) begin
            lk_index = IDX_W'(SUB_INDEX);
        end
    end

    // Blank the row when the row is out of range, or the code is unmapped in blank mode
    assign lk_zero    = lk_row_bad || (!lk_mapped && (INVALID_MODE == INVALID_MODE_BLANK));
    assign lk_invalid = lk_row_bad || !lk_mapped;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic             s1_valid;
    logic [IDX_W-1:0] s1_index;
    logic [ROW_W-1:0] s1_row;
    logic             s1_zero;
    logic             s1_invalid;
    logic             s1_adv;

    logic             s2_valid;
    logic [IDX_W-1:0] s2_index;
    logic             s2_zero;
    logic             s2_invalid;

    assign s1_adv    = !s2_valid || out_ready;
    assign req_ready = !s1_valid || s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_index   <= '0;
            s1_row     <= '0;
            s1_zero    <= 1'b0;
            s1_invalid <= 1'b0;
        end else if (req_ready) begin
            s1_valid <= req_valid;
            if (req_valid) begin
                s1_index   <= lk_index;
                s1_row     <= req_row;
                s1_zero    <= lk_zero;
                s1_invalid <= lk_invalid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_index   <= '0;
            s2_zero    <= 1'b0;
            s2_invalid <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_index   <= s1_index;
                s2_zero    <= s1_zero;
                s2_invalid <= s1_invalid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 fetch: the RAM read register is the stage-2 data register, so it
    // is only enabled when stage 2 loads; this keeps out_bits stable on stall.
    // ------------------------------------------------------------------
    logic [CHAR_W-1:0] ram_rd_data;

    char_font_ram #(
        .DATA_W (CHAR_W),
        .ADDR_W (IDX_W + ROW_W)
    ) u_font_ram (
        .clk     (clk),
        .wr_en   (font_we),
        .wr_addr (font_addr),
        .wr_data (font_data),
        .rd_en   (s1_adv && s1_valid),
        .rd_addr ({s1_index, s1_row}),
        .rd_data (ram_rd_data)
    );

    // Gating with s2_valid keeps unreset RAM data off the bus after reset
    assign out_bits    = (s2_valid && !s2_zero) ? ram_rd_data : '0;
    assign out_valid   = s2_valid;
    assign out_index   = s2_index;
    assign out_invalid = s2_invalid;

    // ------------------------------------------------------------------
    // Invalid-result counter (clear wins over increment, saturates)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invalid_cnt <= '0;
        end else if (cnt_clr) begin
            invalid_cnt <= '0;
        end else if (out_valid && out_ready && out_invalid && (invalid_cnt != '1)) begin
            invalid_cnt <= invalid_cnt + 16'd1;
        end
    end

endmodule

// File: doc/char_glyph_engine.md
# char_glyph_engine

Parametrised, pipelined successor to the fixed ASCII-to-compact-index mapper. It accepts character render requests (ASCII code plus glyph row) over a valid/ready handshake. It remaps the code through a runtime-loadable table, fetches the glyph row from an internal font RAM, and returns CHAR_W pixel bits. It sits between the OSD/text layout logic and the pixel serializer in the HDMI overlay path, and counts unmapped characters for debug.

## Interface
- CHAR_W, 8, glyph width in pixels (bits per row)
- CHAR_H, 16, glyph height in rows
- NUM_CHARS, 64, compact glyph slots; IDX_W = clog2(NUM_CHARS), ROW_W = clog2(CHAR_H)
- INVALID_MODE, 0, 0 = render blank row for unmapped codes, 1 = render glyph SUB_INDEX
- SUB_INDEX, 0, substitute slot used when INVALID_MODE = 1
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1  request handshake
- req_ascii  in  8  ASCII code
- req_row  in  ROW_W  glyph row
- out_valid / out_ready  out / in  1  result handshake
- out_bits  out  CHAR_W  pixel row, MSB = leftmost pixel
- out_index  out  IDX_W  resolved slot
- out_invalid  out  1  code unmapped, or row ≥ CHAR_H
- map_we  in  1  remap table write strobe
- map_ascii  in  8  table address
- map_index  in  IDX_W  slot to store
- map_en  in  1  entry valid bit to store
- font_we  in  1  font RAM write strobe
- font_addr  in  IDX_W+ROW_W  address: {index, row}
- font_data  in  CHAR_W  row pattern
- invalid_cnt  out  16  saturating count of invalid results delivered
- cnt_clr  in  1  synchronous clear of invalid_cnt

## Operation
- Stage 1 (lookup): on accept, read remap entry for req_ascii and register index, valid bit, row, and row-range check.
- Unmapped code (entry valid bit 0):
  - INVALID_MODE 0: index forced to 0, bits forced to 0.
  - INVALID_MODE 1: index forced to SUB_INDEX, glyph fetched normally.
- Row ≥ CHAR_H (only possible when CHAR_H is not a power of 2): bits forced to 0, out_invalid = 1.
- Stage 2 (fetch): synchronous font RAM read at {index, row}; the force-to-zero rules are applied at the output mux.
- Remap table: 256 × IDX_W data, unreset. The separate 256-bit valid vector is cleared by reset, so every code is invalid until loaded.
- Font RAM contents are unreset and undefined until written.
- Table and RAM writes are independent of the pipeline and take effect in the cycle after the strobe.
- Reads are read-first: a write and a lookup to the same address in the same cycle return the old value.
- invalid_cnt increments on each out_valid && out_ready with out_invalid = 1 and saturates at 16'hFFFF.
- cnt_clr has priority over the increment.

## Timing
- Latency: 2 cycles from accept to out_valid; throughput 1 result per cycle when out_ready = 1.
- Backpressure: both stages hold while out_valid && !out_ready. Ready chain:
  - req_ready = !s1_valid || s1_adv
  - s1_adv = !s2_valid || out_ready
- No combinational path from req_valid to out_valid. The only combinational path to req_ready is from out_ready.
- out_bits, out_index and out_invalid hold stable while stalled.
- Reset values: out_valid 0, out_bits 0, out_index 0, out_invalid 0, invalid_cnt 0, req_ready 1 once rst_n is released. All stage valid flags are 0.
- Reset asserted mid-stream drops in-flight requests, with no output after release.

## Structure
- Shared package/header char_font_pkg: clog2 function, INVALID_MODE_BLANK = 0 / INVALID_MODE_SUB = 1 constants, default CHAR_W/CHAR_H/NUM_CHARS.
- Sub-module char_font_ram: simple dual-port synchronous RAM, NUM_CHARS*CHAR_H × CHAR_W, registered read; inferred block RAM.
- Remap table in top level, distributed RAM plus valid flop vector.

## Test plan
- Reset then request 'A' row 3 with no table writes -> out_invalid = 1, out_bits = 0, invalid_cnt = 1.
- Map 'A'(65) -> slot 14 with map_en = 1, font {14,3} = 8'h3C, request 'A' row 3 -> out_bits = 8'h3C, out_index = 14, 2 cycles after accept.
- Stream 8 back-to-back requests with out_ready toggling 1010… -> all 8 results in order, no loss or duplication, outputs stable while stalled.
- INVALID_MODE = 1, SUB_INDEX = 5, font {5,0} = 8'hFF, request unmapped 'Z' row 0 -> out_bits = 8'hFF, out_index = 5, out_invalid = 1.
- map_we and a lookup to the same code in the same cycle -> old entry used; next lookup uses the new one.
- Preload invalid_cnt to 16'hFFFE via invalid requests, then send 3 more -> counter saturates at 16'hFFFF. Assert cnt_clr together with an invalid result -> counter reads 0.
